// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative shift-add multiply / restoring divide with HI/LO results
// Optional signed support is compiled in with MULDIV_SIGNED_EN.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t             state;
  logic [CW-1:0]      cnt;
  logic               op_q;
  logic [WIDTH-1:0]   opnd;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   rem;

  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;

`ifdef MULDIV_SIGNED_EN
  logic neg_res;
  logic neg_rem;
  logic a_neg;
  logic b_neg;

  assign a_neg = is_signed & a[WIDTH-1];
  assign b_neg = is_signed & b[WIDTH-1];
  assign mag_a = a_neg ? -a : a;
  assign mag_b = b_neg ? -b : b;
`else
  logic unused_is_signed;

  assign unused_is_signed = is_signed;
  assign mag_a = a;
  assign mag_b = b;
`endif

  // Multiply: opnd is the multiplicand, acc[WIDTH-1:0] shifts the multiplier out LSB first.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;

  assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
  assign mul_next = {mul_sum, acc[WIDTH-1:1]};

  // Divide: opnd is the divisor, acc[WIDTH-1:0] shifts the dividend out MSB first
  // while quotient bits shift in at the bottom.
  logic [WIDTH:0]   div_shift;
  logic             div_ge;
  logic [WIDTH-1:0] div_sub;
  logic [WIDTH-1:0] div_rem_next;
  logic [WIDTH-1:0] div_q_next;

  assign div_shift    = {rem, acc[WIDTH-1]};
  assign div_ge       = div_shift >= {1'b0, opnd};
  assign div_sub      = div_shift[WIDTH-1:0] - opnd;
  assign div_rem_next = div_ge ? div_sub : div_shift[WIDTH-1:0];
  assign div_q_next   = {acc[WIDTH-2:0], div_ge};

  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rmd;

  always_comb begin
    prod = mul_next;
    quo  = div_q_next;
    rmd  = div_rem_next;
`ifdef MULDIV_SIGNED_EN
    if (neg_res) begin
      prod = -mul_next;
      quo  = -div_q_next;
    end
    if (neg_rem) begin
      rmd = -div_rem_next;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      op_q        <= 1'b0;
      opnd        <= '0;
      acc         <= '0;
      rem         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      hi          <= '0;
      lo          <= '0;
`ifdef MULDIV_SIGNED_EN
      neg_res     <= 1'b0;
      neg_rem     <= 1'b0;
`endif
    end else begin
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (op && (b == '0)) begin
              // Zero divisor finishes immediately without entering RUN.
              state       <= S_DONE;
              done        <= 1'b1;
              div_by_zero <= 1'b1;
              hi          <= a;
              lo          <= '1;
            end else begin
              state <= S_RUN;
              busy  <= 1'b1;
              cnt   <= '0;
              op_q  <= op;
              opnd  <= op ? mag_b : mag_a;
              acc   <= {{WIDTH{1'b0}}, (op ? mag_a : mag_b)};
              rem   <= '0;
`ifdef MULDIV_SIGNED_EN
              neg_res <= a_neg ^ b_neg;
              neg_rem <= a_neg;
`endif
            end
          end
        end
        S_RUN: begin
          cnt <= cnt + 1'b1;
          if (op_q) begin
            acc[WIDTH-1:0] <= div_q_next;
            rem            <= div_rem_next;
          end else begin
            acc <= mul_next;
          end
          if (cnt == CW'(WIDTH - 1)) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            if (op_q) begin
              hi <= rmd;
              lo <= quo;
            end else begin
              hi <= prod[2*WIDTH-1:WIDTH];
              lo <= prod[WIDTH-1:0];
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - self-checking bench for muldiv_unit against an arithmetic reference model
module tb_muldiv_unit;

  localparam int W = 32;
`ifdef MULDIV_SIGNED_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         op;
  logic         is_signed;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic         div_by_zero;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int passed = 0;
  int total  = 0;

  logic         ro;
  logic         rs;
  logic [W-1:0] rx;
  logic [W-1:0] ry;
  int           seen_done;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .op          (op),
    .is_signed   (is_signed),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .hi          (hi),
    .lo          (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference: plain integer arithmetic on the operands.
  function automatic void model(input logic o, input logic s, input logic [W-1:0] x,
                                input logic [W-1:0] y, output logic [W-1:0] eh,
                                output logic [W-1:0] el, output logic ed);
    logic [63:0] p;
    longint      sx;
    longint      sy;
    int          ix;
    int          iy;
    logic        sg;
    sg = s && SIGNED_EN;
    ed = 1'b0;
    if (o && y == '0) begin
      eh = x;
      el = '1;
      ed = 1'b1;
    end else if (!o) begin
      if (sg) begin
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        p  = sx * sy;
      end else begin
        p = {32'b0, x} * {32'b0, y};
      end
      eh = p[63:32];
      el = p[31:0];
    end else if (sg) begin
      if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
        el = x;
        eh = '0;
      end else begin
        ix = x;
        iy = y;
        el = ix / iy;
        eh = ix % iy;
      end
    end else begin
      el = x / y;
      eh = x % y;
    end
  endfunction

  task automatic run_op(input logic o, input logic s, input logic [W-1:0] x,
                        input logic [W-1:0] y, input bit poke);
    logic [W-1:0] eh;
    logic [W-1:0] el;
    logic         ed;
    int           n;
    int           bc;
    model(o, s, x, y, eh, el, ed);
    @(posedge clk); #1;
    start = 1'b1; op = o; is_signed = s; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0; op = 1'($urandom); a = $urandom; b = $urandom;
    n  = 0;
    bc = 0;
    while (done !== 1'b1 && n < 100) begin
      if (busy === 1'b1) bc++;
      if (poke && n == 5) start = 1'b1;
      if (poke && n == 6) start = 1'b0;
      @(posedge clk); #1;
      n++;
    end
    if (ed) begin
      check("zdiv_latency", n, 0);
    end else begin
      check("latency", n, W);
      check("busy_cycles", bc, W);
    end
    check("busy_at_done", busy, 0);
    check("hi", hi, eh);
    check("lo", lo, el);
    check("div_by_zero", div_by_zero, ed);
    // start during DONE must be ignored
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("done_pulse", done, 0);
    check("busy_after", busy, 0);
    check("dbz_after", div_by_zero, 0);
    check("hi_hold", hi, eh);
    check("lo_hold", lo, el);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = 1'b0; op = 1'b0; is_signed = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_dbz", div_by_zero, 0);
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    rst = 1'b0;

    run_op(1'b0, 1'b0, 32'd7, 32'd6, 1'b0);
    run_op(1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    run_op(1'b1, 1'b0, 32'd100, 32'd7, 1'b0);
    run_op(1'b1, 1'b0, 32'd5, 32'd0, 1'b0);
    run_op(1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0);
    run_op(1'b0, 1'b1, 32'hFFFF_FFFD, 32'd4, 1'b0);
    run_op(1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op(1'b1, 1'b1, 32'hFFFF_FFF7, 32'd0, 1'b0);

    // Reset in the middle of a multiply
    @(posedge clk); #1;
    start = 1'b1; op = 1'b0; is_signed = 1'b0; a = 32'd123456; b = 32'd654321;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_hi", hi, 0);
    check("midrst_lo", lo, 0);
    seen_done = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done === 1'b1) seen_done++;
    end
    check("midrst_no_done", seen_done, 0);
    run_op(1'b0, 1'b0, 32'd3, 32'd3, 1'b0);

    repeat (24) begin
      ro = 1'($urandom);
      rs = 1'($urandom);
      rx = ($urandom % 8 == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom % 4)
        0:       ry = '0;
        1:       ry = $urandom % 16;
        2:       ry = 32'hFFFF_FFFF;
        default: ry = $urandom;
      endcase
      run_op(ro, rs, rx, ry, 1'($urandom));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
